// File: rtl/dbg_bus_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : dbg_bus_initiator_if
// Description : Command/response stream and memory-bus signals of the debug
//               bus initiator, bundled with initiator (master) and
//               environment (slave) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface dbg_bus_initiator_if #(
    parameter int LEN_WIDTH = 8
);
    // Command stream from the debug bridge
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [31:0]          cmd_addr;
    logic [31:0]          cmd_wdata;
    logic [3:0]           cmd_be;
    logic [LEN_WIDTH-1:0] cmd_len;

    // Response stream back to the bridge
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;

    // Memory-mapped bus towards the arbiter and responders
    logic                 bus_req;
    logic                 bus_gnt;
    logic [31:0]          address;
    logic [31:0]          write_data;
    logic [3:0]           write_enable;
    logic [31:0]          read_data;

    // Initiator view
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, cmd_len,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output bus_req, address, write_data, write_enable,
        input  bus_gnt, read_data
    );

    // Bridge / arbiter / responder view
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, cmd_len,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  bus_req, address, write_data, write_enable,
        output bus_gnt, read_data
    );
endinterface
`default_nettype wire

// File: rtl/dbg_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : dbg_bus_initiator
// Description : Debug-side bus master. Accepts read/write commands, requests
//               the bus, performs incrementing read bursts and fill write
//               bursts, and returns one response per read word or one per
//               write command.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_bus_initiator #(
    parameter int READ_LATENCY = 1,  // 1..4
    parameter int LEN_WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    dbg_bus_initiator_if.master bus,
    output logic                busy
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_req  = 3'd1;
    localparam logic [2:0] c_st_addr = 3'd2;
    localparam logic [2:0] c_st_wait = 3'd3;
    localparam logic [2:0] c_st_rsp  = 3'd4;

    localparam logic [1:0]           c_wait_init = 2'(READ_LATENCY - 1);
    localparam logic [LEN_WIDTH-1:0] c_len_one   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]           r_state;
    logic                 r_write;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_be;
    logic [LEN_WIDTH-1:0] r_cnt;   // words remaining after the current one
    logic [1:0]           r_wait;

    logic                 w_last;
    logic [31:0]          w_next_addr;

    assign w_last      = (r_cnt == '0);
    // Wraps modulo 2**32 by construction
    assign w_next_addr = r_addr + 32'd4;

    // Single FSM: state, burst bookkeeping and every registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_st_idle;
            r_write          <= 1'b0;
            r_addr           <= 32'd0;
            r_wdata          <= 32'd0;
            r_be             <= 4'd0;
            r_cnt            <= '0;
            r_wait           <= 2'd0;
            busy             <= 1'b0;
            bus.cmd_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= 32'd0;
            bus.rsp_err      <= 1'b0;
            bus.bus_req      <= 1'b0;
            bus.address      <= 32'd0;
            bus.write_data   <= 32'd0;
            bus.write_enable <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        r_write       <= bus.cmd_write;
                        r_addr        <= bus.cmd_addr;
                        r_wdata       <= bus.cmd_wdata;
                        r_be          <= bus.cmd_be;
                        r_cnt         <= bus.cmd_len;
                        bus.cmd_ready <= 1'b0;
                        busy          <= 1'b1;
                        if (bus.cmd_addr[1:0] != 2'b00) begin
                            // Misaligned: answer with an error, never touch the bus
                            r_state       <= c_st_rsp;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= 32'd0;
                        end else begin
                            r_state     <= c_st_req;
                            bus.bus_req <= 1'b1;
                        end
                    end
                end

                c_st_req: begin
                    if (bus.bus_gnt) begin
                        r_state     <= c_st_addr;
                        bus.address <= r_addr;
                        if (r_write) begin
                            bus.write_data   <= r_wdata;
                            bus.write_enable <= r_be;
                        end
                    end
                end

                c_st_addr: begin
                    if (r_write) begin
                        if (w_last) begin
                            r_state          <= c_st_rsp;
                            bus.rsp_valid    <= 1'b1;
                            bus.rsp_err      <= 1'b0;
                            bus.rsp_rdata    <= 32'd0;
                            bus.bus_req      <= 1'b0;
                            bus.address      <= 32'd0;
                            bus.write_data   <= 32'd0;
                            bus.write_enable <= 4'd0;
                        end else begin
                            r_addr <= w_next_addr;
                            r_cnt  <= r_cnt - c_len_one;
                            if (bus.bus_gnt) begin
                                // Back-to-back fill beat: data and strobes stay put
                                bus.address <= w_next_addr;
                            end else begin
                                r_state          <= c_st_req;
                                bus.address      <= 32'd0;
                                bus.write_data   <= 32'd0;
                                bus.write_enable <= 4'd0;
                            end
                        end
                    end else begin
                        r_state <= c_st_wait;
                        r_wait  <= c_wait_init;
                    end
                end

                c_st_wait: begin
                    if (r_wait == 2'd0) begin
                        r_state       <= c_st_rsp;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= bus.read_data;
                        bus.rsp_err   <= 1'b0;
                        bus.address   <= 32'd0;
                        bus.bus_req   <= !w_last;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end

                c_st_rsp: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= 32'd0;
                        bus.rsp_err   <= 1'b0;
                        if (!r_write && !bus.rsp_err && !w_last) begin
                            // Next word of a read burst; bus_req is still held
                            r_addr <= w_next_addr;
                            r_cnt  <= r_cnt - c_len_one;
                            if (bus.bus_gnt) begin
                                r_state     <= c_st_addr;
                                bus.address <= w_next_addr;
                            end else begin
                                r_state <= c_st_req;
                            end
                        end else begin
                            r_state       <= c_st_idle;
                            bus.cmd_ready <= 1'b1;
                            bus.bus_req   <= 1'b0;
                            busy          <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state          <= c_st_idle;
                    bus.cmd_ready    <= 1'b1;
                    bus.rsp_valid    <= 1'b0;
                    bus.bus_req      <= 1'b0;
                    bus.address      <= 32'd0;
                    bus.write_data   <= 32'd0;
                    bus.write_enable <= 4'd0;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
